// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 codes, FSM states and legality check for the data-memory responder
package dmem_pkg;
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;

   function automatic logic is_legal(input logic we, input logic [2:0] funct3);
      return we ? (funct3 <= F3_W)
                : (funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                   funct3 == F3_BU || funct3 == F3_HU);
   endfunction
endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response handshake bundle between a load/store master and the responder
//   request : req_valid/req_ready, req_we, req_funct3, req_addr, req_wdata
//   response: rsp_valid/rsp_ready, rsp_rdata, rsp_err
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_load_format.sv
// dmem_load_format: sign/zero-extends four little-endian raw bytes according to a load funct3
//   raw    : bytes addr+0..addr+3, byte 0 in [7:0]
//   funct3 : load width/sign code
//   data   : formatted value, 0 for illegal codes
module dmem_load_format
   import dmem_pkg::*;
(
   input  logic [31:0] raw,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);
   always_comb begin
      data = funct3 == F3_B  ? {{24{raw[7]}}, raw[7:0]}   :
             funct3 == F3_H  ? {{16{raw[15]}}, raw[15:0]} :
             funct3 == F3_W  ? raw                        :
             funct3 == F3_BU ? {24'd0, raw[7:0]}          :
             funct3 == F3_HU ? {16'd0, raw[15:0]}         : 32'd0;
   end
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: byte-addressed little-endian load/store responder with programmable wait states
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of the request/response handshake
//   memory   : byte array, not reset, preloadable by hierarchical reference
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int DATA_BYTES  = 128,
   parameter int WAIT_CYCLES = 1
) (
   input logic clk,
   input logic rst,
   data_mem_responder_if.slave bus
);
   localparam int AW = $clog2(DATA_BYTES);

   logic [7:0]    memory [DATA_BYTES];
   state_t        state;
   logic [3:0]    cnt;
   logic          cap_we;
   logic [2:0]    cap_f3;
   logic [AW-1:0] cap_addr;
   logic [31:0]   cap_wdata;
   logic [AW-1:0] idx [4];
   logic [31:0]   raw;
   logic [31:0]   fmt;
   logic          legal;
   logic          unused_addr;

   // high address bits select nothing: the array wraps
   assign unused_addr = ^bus.req_addr[31:AW];
   assign bus.req_ready = state == IDLE && !rst;
   assign legal = is_legal(cap_we, cap_f3);

   // each byte lane wraps on its own, so misaligned accesses straddle the array end
   always_comb begin
      raw = '0;
      for (int i = 0; i < 4; i++) begin
         idx[i] = cap_addr + AW'(i);
         raw[8*i +: 8] = memory[idx[i]];
      end
   end

   dmem_load_format u_fmt (
      .raw(raw),
      .funct3(cap_f3),
      .data(fmt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         cap_we        <= 1'b0;
         cap_f3        <= '0;
         cap_addr      <= '0;
         cap_wdata     <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.req_valid) begin
               cap_we    <= bus.req_we;
               cap_f3    <= bus.req_funct3;
               cap_addr  <= bus.req_addr[AW-1:0];
               cap_wdata <= bus.req_wdata;
               cnt       <= 4'(WAIT_CYCLES);
               state     <= WAIT_CYCLES == 0 ? ACCESS : WAIT;
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= ACCESS;
            end
            ACCESS: begin
               bus.rsp_rdata <= (!cap_we && legal) ? fmt : 32'd0;
               bus.rsp_err   <= !legal;
               bus.rsp_valid <= 1'b1;
               state         <= RESP;
            end
            RESP: if (bus.rsp_ready) begin
               bus.rsp_valid <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

   // stores commit only at the closing edge of ACCESS; a reset before then drops them
   always_ff @(posedge clk) begin
      if (state == ACCESS && cap_we && legal) begin
         memory[idx[0]] <= cap_wdata[7:0];
         if (cap_f3 != F3_B) memory[idx[1]] <= cap_wdata[15:8];
         if (cap_f3 == F3_W) begin
            memory[idx[2]] <= cap_wdata[23:16];
            memory[idx[3]] <= cap_wdata[31:24];
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed self-checking bench for data_mem_responder (wait states 1 and 4)
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic rst1 = 1'b1;
   logic rst2 = 1'b1;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_mem_responder_if i1 ();
   data_mem_responder_if i2 ();

   data_mem_responder #(.DATA_BYTES(128), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(i1.slave));
   data_mem_responder #(.DATA_BYTES(128), .WAIT_CYCLES(4)) dut2 (.clk(clk), .rst(rst2), .bus(i2.slave));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic send1(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata);
      @(negedge clk);
      i1.req_valid = 1'b1;
      i1.req_we = we;
      i1.req_funct3 = f3;
      i1.req_addr = addr;
      i1.req_wdata = wdata;
      @(negedge clk);
      i1.req_valid = 1'b0;
   endtask

   task automatic wait1(output int n);
      n = 1;
      while (!i1.rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic take1;
      i1.rsp_ready = 1'b1;
      @(negedge clk);
      i1.rsp_ready = 1'b0;
   endtask

   task automatic xact1(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] d, output logic e, output int n);
      send1(we, f3, addr, wdata);
      wait1(n);
      d = i1.rsp_rdata;
      e = i1.rsp_err;
      take1();
   endtask

   logic [31:0] d, held;
   logic e;
   int n;

   initial begin
      i1.req_valid = 0; i1.req_we = 0; i1.req_funct3 = 0; i1.req_addr = 0; i1.req_wdata = 0; i1.rsp_ready = 0;
      i2.req_valid = 0; i2.req_we = 0; i2.req_funct3 = 0; i2.req_addr = 0; i2.req_wdata = 0; i2.rsp_ready = 0;
      for (int i = 0; i < 128; i++) begin
         dut1.memory[i] = 8'h00;
         dut2.memory[i] = 8'h00;
      end
      repeat (2) @(negedge clk);
      chk("rst_req_ready", 32'(i1.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(i1.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", i1.rsp_rdata, 32'd0);
      chk("rst_rsp_err", 32'(i1.rsp_err), 32'd0);
      rst1 = 1'b0;
      rst2 = 1'b0;
      @(negedge clk);
      chk("idle_req_ready", 32'(i1.req_ready), 32'd1);

      dut1.memory[4] = 8'h7f; dut1.memory[5] = 8'h7f; dut1.memory[6] = 8'h00; dut1.memory[7] = 8'h00;
      xact1(1'b0, 3'b010, 32'd4, 32'd0, d, e, n);
      chk("lw4_data", d, 32'h00007f7f);
      chk("lw4_err", 32'(e), 32'd0);
      chk("lw4_latency", 32'(n), 32'd3);

      dut1.memory[0] = 8'h7f; dut1.memory[1] = 8'h7f; dut1.memory[2] = 8'hf7; dut1.memory[3] = 8'hf7;
      xact1(1'b0, 3'b010, 32'd128, 32'd0, d, e, n);
      chk("lw128_wrap", d, 32'hf7f77f7f);

      dut1.memory[126] = 8'h11; dut1.memory[127] = 8'h22; dut1.memory[0] = 8'h33; dut1.memory[1] = 8'h44;
      xact1(1'b0, 3'b010, 32'd126, 32'd0, d, e, n);
      chk("lw126_straddle", d, 32'h44332211);

      dut1.memory[8] = 8'h00; dut1.memory[9] = 8'h88;
      xact1(1'b0, 3'b000, 32'd9, 32'd0, d, e, n);
      chk("lb9", d, 32'hffffff88);
      xact1(1'b0, 3'b100, 32'hffff_ff09, 32'd0, d, e, n);
      chk("lbu9_highaddr", d, 32'h00000088);
      xact1(1'b0, 3'b001, 32'd8, 32'd0, d, e, n);
      chk("lh8", d, 32'hffff8800);
      xact1(1'b0, 3'b101, 32'd8, 32'd0, d, e, n);
      chk("lhu8", d, 32'h00008800);

      dut1.memory[4] = 8'h00; dut1.memory[5] = 8'h00; dut1.memory[8] = 8'h5a;
      xact1(1'b1, 3'b001, 32'd6, 32'habcd1234, d, e, n);
      chk("sh_rdata", d, 32'd0);
      chk("sh_err", 32'(e), 32'd0);
      chk("sh_mem6", 32'(dut1.memory[6]), 32'h34);
      chk("sh_mem7", 32'(dut1.memory[7]), 32'h12);
      chk("sh_mem8", 32'(dut1.memory[8]), 32'h5a);
      xact1(1'b0, 3'b010, 32'd4, 32'd0, d, e, n);
      chk("lw4_after_sh", d, 32'h12340000);

      xact1(1'b1, 3'b000, 32'd129, 32'h000000a5, d, e, n);
      chk("sb_mem1", 32'(dut1.memory[1]), 32'ha5);
      chk("sb_mem2", 32'(dut1.memory[2]), 32'hf7);

      xact1(1'b1, 3'b010, 32'd126, 32'hdeadbeef, d, e, n);
      chk("sw_wrap", {dut1.memory[1], dut1.memory[0], dut1.memory[127], dut1.memory[126]}, 32'hdeadbeef);

      send1(1'b0, 3'b010, 32'd4, 32'd0);
      wait1(n);
      chk("bp_latency", 32'(n), 32'd3);
      held = i1.rsp_rdata;
      chk("bp_data", held, 32'h12340000);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", 32'(i1.rsp_valid), 32'd1);
         chk("bp_stable", i1.rsp_rdata, held);
         chk("bp_req_ready", 32'(i1.req_ready), 32'd0);
      end
      take1();
      chk("bp_release_ready", 32'(i1.req_ready), 32'd1);
      chk("bp_release_valid", 32'(i1.rsp_valid), 32'd0);

      xact1(1'b0, 3'b011, 32'd4, 32'd0, d, e, n);
      chk("ill_ld011_err", 32'(e), 32'd1);
      chk("ill_ld011_data", d, 32'd0);
      xact1(1'b0, 3'b110, 32'd4, 32'd0, d, e, n);
      chk("ill_ld110_err", 32'(e), 32'd1);
      dut1.memory[20] = 8'h66;
      xact1(1'b1, 3'b011, 32'd20, 32'hffffffff, d, e, n);
      chk("ill_st_err", 32'(e), 32'd1);
      chk("ill_st_mem", 32'(dut1.memory[20]), 32'h66);

      dut2.memory[0] = 8'h01; dut2.memory[1] = 8'h02; dut2.memory[2] = 8'h03; dut2.memory[3] = 8'h04;
      @(negedge clk);
      i2.req_valid = 1'b1; i2.req_we = 1'b1; i2.req_funct3 = 3'b010; i2.req_addr = 32'd0; i2.req_wdata = 32'hdeadbeef;
      @(negedge clk);
      i2.req_valid = 1'b0;
      @(negedge clk);
      rst2 = 1'b1;
      #1;
      chk("w4_rst_req_ready", 32'(i2.req_ready), 32'd0);
      repeat (2) @(negedge clk);
      rst2 = 1'b0;
      repeat (8) @(negedge clk);
      chk("w4_rst_valid", 32'(i2.rsp_valid), 32'd0);
      chk("w4_rst_req_ready_after", 32'(i2.req_ready), 32'd1);
      chk("w4_rst_mem", {dut2.memory[3], dut2.memory[2], dut2.memory[1], dut2.memory[0]}, 32'h04030201);

      i2.req_valid = 1'b1; i2.req_we = 1'b0; i2.req_funct3 = 3'b010; i2.req_addr = 32'd0;
      @(negedge clk);
      i2.req_valid = 1'b0;
      n = 1;
      while (!i2.rsp_valid && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("w4_latency", 32'(n), 32'd6);
      chk("w4_lw0", i2.rsp_rdata, 32'h04030201);
      i2.rsp_ready = 1'b1;
      @(negedge clk);
      i2.rsp_ready = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
